// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and
// vector-table layout constants.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REQ     = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_e;

    localparam logic [15:0] IC_VECTOR_BASE = 16'h0010;
    localparam int          IC_VEC_STRIDE  = 4;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: the lowest set index wins.
module interrupt_controller_priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan from the top so the last (lowest) hit overrides.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller: pending capture, mask, fixed
// priority and a single-level req/ack/return handshake to the control unit.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IC_IDLE    | no request outstanding; pick a winner from pending & ~mask
// IC_REQ     | int_req high, id and vector frozen until int_ack
// IC_SERVICE | handler running, nesting blocked until rit
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                NUM_SRC     = 8,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] VECTOR_BASE = ADDR_W'(IC_VECTOR_BASE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic [NUM_SRC-1:0] pend_clr,
    input  logic               int_ack,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               rit,
    output logic               int_req,
    output logic [ADDR_W-1:0]  int_vector,
    output logic               int_active,
    output logic [ADDR_W-1:0]  ret_addr,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    ic_state_e          state_q, state_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic               int_req_q, int_req_d;
    logic               int_active_q, int_active_d;
    logic [ADDR_W-1:0]  vector_q, vector_d;
    logic [ADDR_W-1:0]  ret_q, ret_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] irq_rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic               ack_take;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  win_vector;

    assign eligible = pending_q & ~mask_q;

    interrupt_controller_priority_encoder #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_priority_encoder (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Wraps modulo 2^ADDR_W by construction of the operand widths.
    assign win_vector = VECTOR_BASE + ADDR_W'(win_idx) * ADDR_W'(IC_VEC_STRIDE);

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        int_req_d    = int_req_q;
        int_active_d = int_active_q;
        vector_d     = vector_q;
        ret_d        = ret_q;
        ack_take     = 1'b0;

        irq_rise = irq & ~irq_q;
        mask_d   = mask_wr ? mask_data : mask_q;

        case (state_q)
            IC_IDLE: begin
                if (win_valid) begin
                    id_d      = win_idx;
                    vector_d  = win_vector;
                    int_req_d = 1'b1;
                    state_d   = IC_REQ;
                end
            end
            IC_REQ: begin
                if (int_ack) begin
                    ack_take     = 1'b1;
                    int_req_d    = 1'b0;
                    ret_d        = pc_in;
                    int_active_d = 1'b1;
                    state_d      = IC_SERVICE;
                end
            end
            IC_SERVICE: begin
                if (rit) begin
                    int_active_d = 1'b0;
                    state_d      = IC_IDLE;
                end
            end
            default: begin
                state_d = IC_IDLE;
            end
        endcase

        ack_clr = ack_take ? (NUM_SRC'(1) << id_q) : '0;
        // A new edge in the same cycle as a clear keeps the bit set.
        pending_d = (pending_q & ~(pend_clr | ack_clr)) | irq_rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IC_IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            mask_q       <= '1;
            id_q         <= '0;
            int_req_q    <= 1'b0;
            int_active_q <= 1'b0;
            vector_q     <= '0;
            ret_q        <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            id_q         <= id_d;
            int_req_q    <= int_req_d;
            int_active_q <= int_active_d;
            vector_q     <= vector_d;
            ret_q        <= ret_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_vector = vector_q;
    assign int_active = int_active_q;
    assign ret_addr   = ret_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vector table, reset corner case,
// and randomized traffic compared against a behavioural model.
module tb_interrupt_controller;

    localparam int N  = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq, mask_data, pend_clr;
    logic          mask_wr, int_ack, rit;
    logic [AW-1:0] pc_in;
    logic          int_req, int_active;
    logic [AW-1:0] int_vector, ret_addr;
    logic [N-1:0]  pending, mask;

    interrupt_controller #(.NUM_SRC(N), .ADDR_W(AW), .VECTOR_BASE(16'h0010)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .pend_clr   (pend_clr),
        .int_ack    (int_ack),
        .pc_in      (pc_in),
        .rit        (rit),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_active (int_active),
        .ret_addr   (ret_addr),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  irq;
        logic        mwr;
        logic [7:0]  mdata;
        logic [7:0]  pclr;
        logic        ack;
        logic [15:0] pc;
        logic        rit;
        logic        req;
        logic [15:0] vec;
        logic        act;
        logic [15:0] ret;
        logic [7:0]  pend;
        logic [7:0]  msk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] i_irq, input logic i_mwr, input logic [7:0] i_md,
                       input logic [7:0] i_pclr, input logic i_ack, input logic [15:0] i_pc,
                       input logic i_rit, input logic e_req, input logic [15:0] e_vec,
                       input logic e_act, input logic [15:0] e_ret, input logic [7:0] e_pend,
                       input logic [7:0] e_msk);
        vec_t v;
        v.irq = i_irq; v.mwr = i_mwr; v.mdata = i_md; v.pclr = i_pclr; v.ack = i_ack;
        v.pc = i_pc; v.rit = i_rit; v.req = e_req; v.vec = e_vec; v.act = e_act;
        v.ret = e_ret; v.pend = e_pend; v.msk = e_msk;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        irq = '0; mask_wr = 1'b0; mask_data = '0; pend_clr = '0;
        int_ack = 1'b0; pc_in = '0; rit = 1'b0;
    endtask

    // Behavioural reference: sources as bit arrays, handshake as two flags.
    bit mp[N];
    bit mm[N];
    bit mprev[N];
    bit m_wait_ack, m_in_handler;
    int m_src, m_vec, m_ret;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mp[i] = 1'b0; mm[i] = 1'b1; mprev[i] = 1'b0;
        end
        m_wait_ack = 1'b0; m_in_handler = 1'b0;
        m_src = 0; m_vec = 0; m_ret = 0;
    endtask

    task automatic model_step();
        int win;
        bit np[N];
        win = -1;
        for (int i = 0; i < N; i++)
            if (mp[i] && !mm[i] && win < 0) win = i;
        for (int i = 0; i < N; i++) begin
            np[i] = mp[i];
            if (pend_clr[i]) np[i] = 1'b0;
            if (m_wait_ack && int_ack && m_src == i) np[i] = 1'b0;
            if (irq[i] && !mprev[i]) np[i] = 1'b1;
        end
        if (m_wait_ack) begin
            if (int_ack) begin
                m_wait_ack = 1'b0; m_in_handler = 1'b1; m_ret = int'(pc_in);
            end
        end else if (m_in_handler) begin
            if (rit) m_in_handler = 1'b0;
        end else if (win >= 0) begin
            m_wait_ack = 1'b1; m_src = win; m_vec = (16 + 4 * win) % 65536;
        end
        for (int i = 0; i < N; i++) begin
            mp[i] = np[i];
            if (mask_wr) mm[i] = mask_data[i];
            mprev[i] = irq[i];
        end
    endtask

    function automatic logic [7:0] pack(input bit a[N]);
        logic [7:0] r;
        for (int i = 0; i < N; i++) r[i] = a[i];
        return r;
    endfunction

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req", int_req, 1'b0);
        chk("reset active", int_active, 1'b0);
        chk("reset vector", int_vector, 16'h0000);
        chk("reset ret", ret_addr, 16'h0000);
        chk("reset pending", pending, 8'h00);
        chk("reset mask", mask, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   irq  mwr md   pclr ack pc       rit | req vec       act ret       pend  mask
        add(8'h00,1,8'h00,8'h00,0,16'h0000,0,  0,16'h0000,0,16'h0000,8'h00,8'h00);
        add(8'h08,0,8'h00,8'h00,0,16'h0000,0,  0,16'h0000,0,16'h0000,8'h08,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,0,  1,16'h001C,0,16'h0000,8'h08,8'h00);
        add(8'h00,0,8'h00,8'h00,1,16'h0123,0,  0,16'h001C,1,16'h0123,8'h00,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,1,  0,16'h001C,0,16'h0123,8'h00,8'h00);
        add(8'h24,0,8'h00,8'h00,0,16'h0000,0,  0,16'h001C,0,16'h0123,8'h24,8'h00);
        add(8'h24,0,8'h00,8'h00,0,16'h0000,0,  1,16'h0018,0,16'h0123,8'h24,8'h00);
        add(8'h25,0,8'h00,8'h00,0,16'h0000,0,  1,16'h0018,0,16'h0123,8'h25,8'h00);
        add(8'h00,0,8'h00,8'h00,1,16'h0200,0,  0,16'h0018,1,16'h0200,8'h21,8'h00);
        add(8'h01,0,8'h00,8'h00,0,16'h0000,0,  0,16'h0018,1,16'h0200,8'h21,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,1,  0,16'h0018,0,16'h0200,8'h21,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,0,  1,16'h0010,0,16'h0200,8'h21,8'h00);
        add(8'h00,0,8'h00,8'h00,1,16'h0300,0,  0,16'h0010,1,16'h0300,8'h20,8'h00);
        add(8'h00,0,8'h00,8'h20,0,16'h0000,1,  0,16'h0010,0,16'h0300,8'h00,8'h00);
        add(8'h00,1,8'hFF,8'h00,0,16'h0000,0,  0,16'h0010,0,16'h0300,8'h00,8'hFF);
        add(8'h02,0,8'h00,8'h00,0,16'h0000,0,  0,16'h0010,0,16'h0300,8'h02,8'hFF);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,0,  0,16'h0010,0,16'h0300,8'h02,8'hFF);
        add(8'h00,1,8'h00,8'h00,0,16'h0000,0,  0,16'h0010,0,16'h0300,8'h02,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,0,  1,16'h0014,0,16'h0300,8'h02,8'h00);
        add(8'h00,0,8'h00,8'h00,1,16'h0456,0,  0,16'h0014,1,16'h0456,8'h00,8'h00);
        add(8'h00,0,8'h00,8'h00,1,16'h0555,0,  0,16'h0014,1,16'h0456,8'h00,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,1,  0,16'h0014,0,16'h0456,8'h00,8'h00);
        add(8'h00,0,8'h00,8'h00,1,16'h0666,1,  0,16'h0014,0,16'h0456,8'h00,8'h00);
        add(8'h10,0,8'h00,8'h00,0,16'h0000,0,  0,16'h0014,0,16'h0456,8'h10,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,0,  1,16'h0020,0,16'h0456,8'h10,8'h00);
        add(8'h00,1,8'hFF,8'h10,0,16'h0000,0,  1,16'h0020,0,16'h0456,8'h00,8'hFF);
        add(8'h00,0,8'h00,8'h00,1,16'h0777,0,  0,16'h0020,1,16'h0777,8'h00,8'hFF);
        add(8'h00,1,8'h00,8'h00,0,16'h0000,1,  0,16'h0020,0,16'h0777,8'h00,8'h00);
        add(8'h10,0,8'h00,8'h00,0,16'h0000,0,  0,16'h0020,0,16'h0777,8'h10,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,0,  1,16'h0020,0,16'h0777,8'h10,8'h00);
        add(8'h10,0,8'h00,8'h00,1,16'h0888,0,  0,16'h0020,1,16'h0888,8'h10,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,1,  0,16'h0020,0,16'h0888,8'h10,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,0,  1,16'h0020,0,16'h0888,8'h10,8'h00);
        add(8'h00,0,8'h00,8'h00,1,16'h0999,0,  0,16'h0020,1,16'h0999,8'h00,8'h00);
        add(8'h00,0,8'h00,8'h00,0,16'h0000,1,  0,16'h0020,0,16'h0999,8'h00,8'h00);

        foreach (tbl[i]) begin
            irq = tbl[i].irq; mask_wr = tbl[i].mwr; mask_data = tbl[i].mdata;
            pend_clr = tbl[i].pclr; int_ack = tbl[i].ack; pc_in = tbl[i].pc; rit = tbl[i].rit;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d int_req", i), int_req, tbl[i].req);
            chk($sformatf("row%0d int_vector", i), int_vector, tbl[i].vec);
            chk($sformatf("row%0d int_active", i), int_active, tbl[i].act);
            chk($sformatf("row%0d ret_addr", i), ret_addr, tbl[i].ret);
            chk($sformatf("row%0d pending", i), pending, tbl[i].pend);
            chk($sformatf("row%0d mask", i), mask, tbl[i].msk);
        end

        // Asynchronous reset while a request is outstanding.
        idle_inputs();
        irq = 8'h01;
        @(posedge clk);
        #1;
        irq = 8'h00;
        @(posedge clk);
        #1;
        chk("pre-reset int_req", int_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset int_req", int_req, 1'b0);
        chk("async reset vector", int_vector, 16'h0000);
        chk("async reset ret", ret_addr, 16'h0000);
        chk("async reset pending", pending, 8'h00);
        chk("async reset mask", mask, 8'hFF);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset int_req", int_req, 1'b0);
        chk("post-reset mask", mask, 8'hFF);

        // Randomized traffic against the behavioural model.
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            logic [7:0] flip;
            flip = '0;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(7) == 0);
            irq       = irq ^ flip;
            mask_wr   = ($urandom_range(15) == 0);
            mask_data = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
            pend_clr  = ($urandom_range(15) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
            int_ack   = ($urandom_range(2) == 0);
            rit       = ($urandom_range(3) == 0);
            pc_in     = 16'($urandom);
            model_step();
            @(posedge clk);
            #1;
            chk("rand int_req", int_req, m_wait_ack);
            chk("rand int_active", int_active, m_in_handler);
            chk("rand int_vector", int_vector, 32'(m_vec));
            chk("rand ret_addr", ret_addr, 32'(m_ret));
            chk("rand pending", pending, pack(mp));
            chk("rand mask", mask, pack(mm));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
